// File: rtl/captura_ov7670_grade.sv
// OV7670 grid sampler: stores the centre pixel of each QUAD_C x QUAD_L
// quadrant of a camera frame into a small byte buffer.
module captura_ov7670_grade #(
  parameter  int LARGURA     = 640,
  parameter  int ALTURA      = 480,
  parameter  int BYTES_PIXEL = 2,
  parameter  int QUAD_C      = 3,
  parameter  int QUAD_L      = 3,
  localparam int NQB = QUAD_C * QUAD_L * BYTES_PIXEL,
  localparam int AW  = ($clog2(NQB) < 1) ? 1 : $clog2(NQB)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic          continuo,
  input  logic [3:0]    descarta,
  input  logic          VSYNC,
  input  logic          HREF,
  input  logic          PCLK,
  input  logic [7:0]    D,
  output logic          we_byte,
  output logic [AW-1:0] endereco,
  output logic [7:0]    dado,
  output logic          pronto,
  output logic          ocupado,
  output logic          erro,
  output logic [3:0]    db_estado
);

  localparam int QW     = LARGURA / QUAD_C;
  localparam int QH     = ALTURA / QUAD_L;
  localparam int NBYTES = LARGURA * BYTES_PIXEL;
  localparam int PW     = $clog2(LARGURA + 1);
  localparam int LW     = $clog2(ALTURA + 1);
  localparam int BW     = $clog2(BYTES_PIXEL + 1);
  localparam int SW     = $clog2(NBYTES + 2);
  localparam int CW     = $clog2(QW);
  localparam int RW     = $clog2(QH);
  localparam int QCW    = $clog2(QUAD_C + 1);
  localparam int QLW    = $clog2(QUAD_L + 1);

  localparam logic [PW-1:0] PIX_FIM  = PW'(LARGURA);
  localparam logic [LW-1:0] LIN_FIM  = LW'(ALTURA);
  localparam logic [BW-1:0] BYT_ULT  = BW'(BYTES_PIXEL - 1);
  localparam logic [SW-1:0] VIS_FIM  = SW'(NBYTES);
  localparam logic [SW-1:0] VIS_SAT  = SW'(NBYTES + 1);
  localparam logic [CW-1:0] COL_ULT  = CW'(QW - 1);
  localparam logic [CW-1:0] COL_MEIO = CW'(QW / 2);
  localparam logic [RW-1:0] ROW_ULT  = RW'(QH - 1);
  localparam logic [RW-1:0] ROW_MEIO = RW'(QH / 2);

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    ESPERA_FRAME = 4'd1,
    ESPERA_LINHA = 4'd2,
    ESPERA_BYTE  = 4'd3,
    LE_BYTE      = 4'd4,
    ARMAZENA     = 4'd5,
    FIM_LINHA    = 4'd6,
    FIM_FRAME    = 4'd7
  } estado_t;

  estado_t estado;

  logic [2:0] vs_q;
  logic [2:0] pc_q;
  logic [1:0] hr_q;
  logic [7:0] d_q1, d_q2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vs_q <= '0;
      pc_q <= '0;
      hr_q <= '0;
      d_q1 <= '0;
      d_q2 <= '0;
    end else begin
      vs_q <= {vs_q[1:0], VSYNC};
      pc_q <= {pc_q[1:0], PCLK};
      hr_q <= {hr_q[0], HREF};
      d_q1 <= D;
      d_q2 <= d_q1;
    end
  end

  logic vs_desce, vs_alto, hr_alto, pc_sobe;
  assign vs_desce = ~vs_q[1] & vs_q[2];
  assign vs_alto  = vs_q[1];
  assign hr_alto  = hr_q[1];
  assign pc_sobe  = pc_q[1] & ~pc_q[2];

  logic [PW-1:0]  pix, pix_n;
  logic [LW-1:0]  lin;
  logic [BW-1:0]  byt, byt_n;
  logic [SW-1:0]  vistos, vistos_n;
  logic [CW-1:0]  col, col_n;
  logic [RW-1:0]  row;
  logic [QCW-1:0] qc, qc_n;
  logic [QLW-1:0] ql;
  logic [3:0]     pular;
  logic [7:0]     d_amostra;
  logic           de_byte;
  logic           amostra;

  // col/row are offsets inside the current quadrant, so qc/ql need no divide
  always_comb begin
    vistos_n = (vistos == VIS_SAT) ? vistos : vistos + 1'b1;
    byt_n    = byt + 1'b1;
    pix_n    = pix;
    col_n    = col;
    qc_n     = qc;
    if (byt == BYT_ULT) begin
      byt_n = '0;
      if (pix != PIX_FIM) begin
        pix_n = pix + 1'b1;
        if (col == COL_ULT) begin
          col_n = '0;
          qc_n  = qc + 1'b1;
        end else begin
          col_n = col + 1'b1;
        end
      end
    end
  end

  assign amostra = (pular == 4'd0) && (pix != PIX_FIM) &&
                   (lin != LIN_FIM) && (col == COL_MEIO) &&
                   (row == ROW_MEIO);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= INICIAL;
      we_byte   <= 1'b0;
      endereco  <= '0;
      dado      <= '0;
      pronto    <= 1'b0;
      erro      <= 1'b0;
      pix       <= '0;
      lin       <= '0;
      byt       <= '0;
      vistos    <= '0;
      col       <= '0;
      row       <= '0;
      qc        <= '0;
      ql        <= '0;
      pular     <= '0;
      d_amostra <= '0;
      de_byte   <= 1'b0;
    end else begin
      we_byte <= 1'b0;
      pronto  <= 1'b0;
      case (estado)
        INICIAL: begin
          if (iniciar) begin
            pular  <= descarta;
            erro   <= 1'b0;
            estado <= ESPERA_FRAME;
          end
        end
        ESPERA_FRAME: begin
          if (vs_desce) begin
            lin    <= '0;
            row    <= '0;
            ql     <= '0;
            pix    <= '0;
            col    <= '0;
            qc     <= '0;
            byt    <= '0;
            vistos <= '0;
            estado <= ESPERA_LINHA;
          end
        end
        ESPERA_LINHA: begin
          if (vs_alto) begin
            de_byte <= 1'b0;
            pronto  <= (pular == 4'd0);
            estado  <= FIM_FRAME;
          end else if (hr_alto) begin
            estado <= ESPERA_BYTE;
          end
        end
        ESPERA_BYTE: begin
          if (!hr_alto) begin
            estado <= FIM_LINHA;
          end else if (vs_alto) begin
            de_byte <= 1'b1;
            pronto  <= (pular == 4'd0);
            estado  <= FIM_FRAME;
          end else if (pc_sobe) begin
            d_amostra <= d_q2;
            estado    <= LE_BYTE;
          end
        end
        LE_BYTE: begin
          if (amostra) begin
            we_byte  <= 1'b1;
            endereco <= AW'((int'(ql) * QUAD_C + int'(qc)) *
                            BYTES_PIXEL + int'(byt));
            dado     <= d_amostra;
            estado   <= ARMAZENA;
          end else begin
            pix    <= pix_n;
            col    <= col_n;
            qc     <= qc_n;
            byt    <= byt_n;
            vistos <= vistos_n;
            estado <= ESPERA_BYTE;
          end
        end
        ARMAZENA: begin
          pix    <= pix_n;
          col    <= col_n;
          qc     <= qc_n;
          byt    <= byt_n;
          vistos <= vistos_n;
          estado <= ESPERA_BYTE;
        end
        FIM_LINHA: begin
          if (vistos != VIS_FIM) erro <= 1'b1;
          if (lin != LIN_FIM) begin
            lin <= lin + 1'b1;
            if (row == ROW_ULT) begin
              row <= '0;
              ql  <= ql + 1'b1;
            end else begin
              row <= row + 1'b1;
            end
          end
          pix    <= '0;
          col    <= '0;
          qc     <= '0;
          byt    <= '0;
          vistos <= '0;
          estado <= ESPERA_LINHA;
        end
        FIM_FRAME: begin
          if ((lin != LIN_FIM) || de_byte) erro <= 1'b1;
          if (pular != 4'd0) begin
            pular  <= pular - 1'b1;
            estado <= ESPERA_FRAME;
          end else begin
            estado <= continuo ? ESPERA_FRAME : INICIAL;
          end
        end
        default: estado <= INICIAL;
      endcase
    end
  end

  assign ocupado   = (estado != INICIAL);
  assign db_estado = estado;

endmodule

// File: tb/tb_captura_ov7670_grade.sv
// Bench for captura_ov7670_grade: random camera frames, scenario table,
// reset and stray-iniciar sequences checked against a pixel-grid model.
module tb_captura_ov7670_grade;

  localparam int L = 6, A = 6, BP = 2, QC = 3, QL = 3, AW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          iniciar = 1'b0;
  logic          continuo = 1'b0;
  logic [3:0]    descarta = 4'd0;
  logic          VSYNC = 1'b0, HREF = 1'b0, PCLK = 1'b0;
  logic [7:0]    D = 8'd0;
  logic          we_byte, pronto, ocupado, erro;
  logic [AW-1:0] endereco;
  logic [7:0]    dado;
  logic [3:0]    db_estado;

  always #5 clock = ~clock;

  captura_ov7670_grade #(
    .LARGURA(L), .ALTURA(A), .BYTES_PIXEL(BP), .QUAD_C(QC), .QUAD_L(QL)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .continuo(continuo), .descarta(descarta),
    .VSYNC(VSYNC), .HREF(HREF), .PCLK(PCLK), .D(D),
    .we_byte(we_byte), .endereco(endereco), .dado(dado),
    .pronto(pronto), .ocupado(ocupado), .erro(erro),
    .db_estado(db_estado)
  );

  int checks = 0, fails = 0;
  logic [12:0] got[$];
  logic [12:0] expq[$];
  int npronto = 0;
  int cam_l = -1, cam_b = -1;

  always @(negedge clock) begin
    if (we_byte) got.push_back({endereco, dado});
    if (pronto) npronto++;
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic tick(input logic h, input logic [7:0] d);
    HREF = h;
    D = d;
    #40 PCLK = 1'b1;
    #40 PCLK = 1'b0;
  endtask

  // Camera frame; the model records every byte landing on a grid centre.
  task automatic send_frame(input int short_l, input bit cap);
    logic [7:0] b;
    int nb, p;
    @(posedge clock);
    #2;
    VSYNC = 1'b1;
    repeat (3) tick(1'b0, 8'd0);
    VSYNC = 1'b0;
    repeat (3) tick(1'b0, 8'd0);
    for (int l = 0; l < A; l++) begin
      nb = (l == short_l) ? (L - 1) * BP : L * BP;
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        cam_l = l;
        cam_b = i;
        p = i / BP;
        if (cap && (l % 2 == 1) && (p % 2 == 1))
          expq.push_back({AW'(((l / 2) * QC + p / 2) * BP + i % BP), b});
        tick(1'b1, b);
      end
      repeat (4) tick(1'b0, 8'd0);
    end
    cam_l = -1;
    repeat (3) tick(1'b0, 8'd0);
    VSYNC = 1'b1;
    repeat (3) tick(1'b0, 8'd0);
  endtask

  task automatic pulse_iniciar();
    @(negedge clock) iniciar = 1'b1;
    @(negedge clock) iniciar = 1'b0;
  endtask

  task automatic outs_zero(input string nm);
    chk(nm, int'({we_byte, endereco, dado, pronto, ocupado, erro,
                  db_estado}), 0);
  endtask

  task automatic do_reset();
    @(negedge clock) reset = 1'b0;
    #1 outs_zero("reset_outputs");
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic cmp_bytes(input string nm, input int g0);
    int n;
    n = got.size() - g0;
    chk({nm, "_count_vs_model"}, n, expq.size());
    for (int k = 0; k < n && k < expq.size(); k++)
      chk({nm, "_byte"}, int'(got[g0 + k]), int'(expq[k]));
  endtask

  typedef struct {
    int desc;
    bit cont;
    int frames;
    int short_l;
    bit poke;
    int exp_we;
    int exp_pronto;
    bit exp_erro;
  } vec_t;

  vec_t tbl[6];
  int g0, p0;

  initial begin
    tbl[0] = '{0, 0, 1, -1, 0, 18, 1, 0};
    tbl[1] = '{2, 0, 3, -1, 0, 18, 1, 0};
    tbl[2] = '{0, 1, 3, -1, 0, 54, 3, 0};
    tbl[3] = '{0, 0, 1,  2, 0, 18, 1, 1};
    tbl[4] = '{1, 1, 3, -1, 0, 36, 2, 0};
    tbl[5] = '{0, 0, 1, -1, 1, 18, 1, 0};

    #1 outs_zero("reset_state");

    for (int t = 0; t < 6; t++) begin
      do_reset();
      descarta = 4'(tbl[t].desc);
      continuo = tbl[t].cont;
      g0 = got.size();
      p0 = npronto;
      expq.delete();
      pulse_iniciar();
      chk("ocupado_start", int'(ocupado), 1);
      chk("estado_start", int'(db_estado), 1);
      for (int f = 0; f < tbl[t].frames; f++) begin
        fork
          send_frame(tbl[t].short_l, f >= tbl[t].desc);
          begin
            if (tbl[t].poke) begin
              repeat (3) begin
                repeat ($urandom_range(100, 200)) @(posedge clock);
                pulse_iniciar();
              end
            end
          end
        join
        if (tbl[t].cont) chk("ocupado_between", int'(ocupado), 1);
      end
      repeat (30) @(negedge clock);
      chk("we_count", got.size() - g0, tbl[t].exp_we);
      cmp_bytes("scenario", g0);
      chk("pronto_count", npronto - p0, tbl[t].exp_pronto);
      chk("erro", int'(erro), int'(tbl[t].exp_erro));
      chk("ocupado_end", int'(ocupado), int'(tbl[t].cont));
      if (tbl[t].exp_erro) begin
        repeat (20) @(negedge clock);
        chk("erro_hold", int'(erro), 1);
        pulse_iniciar();
        #1 chk("erro_clear", int'(erro), 0);
      end
    end

    // reset in the middle of a line, then restart on the next frame
    do_reset();
    descarta = 4'd0;
    continuo = 1'b0;
    pulse_iniciar();
    expq.delete();
    fork
      send_frame(-1, 1'b0);
      begin
        int k;
        for (k = 0; k < 5000 && !(cam_l == 2 && cam_b == 3); k++)
          @(posedge clock);
        chk("mid_line_reached", int'(k < 5000), 1);
        #3 reset = 1'b0;
        #1 outs_zero("reset_mid_line");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        g0 = got.size();
        pulse_iniciar();
      end
    join
    repeat (10) @(negedge clock);
    chk("no_we_after_reset", got.size() - g0, 0);
    p0 = npronto;
    send_frame(-1, 1'b1);
    repeat (30) @(negedge clock);
    chk("we_after_reset", got.size() - g0, 18);
    cmp_bytes("after_reset", g0);
    chk("pronto_after_reset", npronto - p0, 1);
    chk("erro_after_reset", int'(erro), 0);
    chk("idle_after_reset", int'(db_estado), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/captura_ov7670_grade.md
CAPTURA_OV7670_GRADE -- requirements
Module: captura_ov7670_grade

Interface
REQ-001 SHALL have parameter LARGURA, default 640, pixels per line.
REQ-002 SHALL have parameter ALTURA, default 480, lines per frame.
REQ-003 SHALL have parameter BYTES_PIXEL, default 2, bytes per pixel (1..4).
REQ-004 SHALL have parameters QUAD_C, default 3, and QUAD_L, default 3: quadrant grid columns and rows. LARGURA/QUAD_C and ALTURA/QUAD_L SHALL be integers ≥2.
REQ-005 SHALL define AW = clog2(QUAD_C*QUAD_L*BYTES_PIXEL), minimum 1.
REQ-006 clock  in  1  single system clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low; low forces reset state.
REQ-008 iniciar  in  1  start capture; level sampled in INICIAL only.
REQ-009 continuo  in  1  1 = re-arm after each frame; 0 = single frame.
REQ-010 descarta  in  4  number of whole frames skipped before first capture.
REQ-011 VSYNC, HREF, PCLK  in  1 each  raw camera signals, asynchronous to clock.
REQ-012 D  in  8  camera data bus.
REQ-013 we_byte  out  1  write strobe, one cycle per sampled byte.
REQ-014 endereco  out  AW  buffer address of sampled byte.
REQ-015 dado  out  8  sampled byte.
REQ-016 pronto  out  1  one-cycle pulse at end of each captured frame.
REQ-017 ocupado  out  1  high in every state except INICIAL.
REQ-018 erro  out  1  sticky geometry error flag.
REQ-019 db_estado  out  4  current state code.

Function
REQ-020 VSYNC, HREF, PCLK and D SHALL each pass through two synchronising flops; a PCLK rising edge SHALL be detected from the 2nd and a 3rd flop, with D taken from its matching delayed stage; clock SHALL be ≥4× PCLK.
REQ-021 States/codes: INICIAL 0, ESPERA_FRAME 1, ESPERA_LINHA 2, ESPERA_BYTE 3, LE_BYTE 4, ARMAZENA 5, FIM_LINHA 6, FIM_FRAME 7; any other value → INICIAL next cycle.
REQ-022 INICIAL→ESPERA_FRAME when iniciar=1; descarta loaded into skip counter, erro cleared.
REQ-023 ESPERA_FRAME: on synced VSYNC falling edge → ESPERA_LINHA; line counter, pixel counter, byte counter zeroed.
REQ-024 ESPERA_LINHA: VSYNC rising → FIM_FRAME; HREF=1 → ESPERA_BYTE.
REQ-025 ESPERA_BYTE: PCLK rising edge → LE_BYTE; HREF falling → FIM_LINHA; VSYNC rising → FIM_FRAME.
REQ-026 LE_BYTE (1 cycle): if skip counter=0 and current pixel is a sample point → ARMAZENA; else advance byte/pixel counters → ESPERA_BYTE.
REQ-027 Sample point: column = qc*(LARGURA/QUAD_C)+(LARGURA/QUAD_C)/2 and line = ql*(ALTURA/QUAD_L)+(ALTURA/QUAD_L)/2 for qc<QUAD_C, ql<QUAD_L.
REQ-028 ARMAZENA (1 cycle): we_byte=1, endereco=(ql*QUAD_C+qc)*BYTES_PIXEL+byte index, dado=sampled D; then advance counters → ESPERA_BYTE.
REQ-029 Byte index wraps at BYTES_PIXEL, advancing pixel counter; pixel counter saturates at LARGURA.
REQ-030 FIM_LINHA (1 cycle): erro set if bytes seen ≠ LARGURA*BYTES_PIXEL; line counter +1 (saturating at ALTURA); pixel/byte counters zeroed → ESPERA_LINHA.
REQ-031 FIM_FRAME (1 cycle): erro set if lines ≠ ALTURA or VSYNC came from ESPERA_BYTE; if skip counter>0, decrement it, no pronto; else pronto=1.
REQ-032 FIM_FRAME next: ESPERA_FRAME if skip counter was >0 or continuo=1; else INICIAL.
REQ-033 Quadrant indices SHALL be derived by counters (no dividers); endereco/dado hold last value outside ARMAZENA.
REQ-034 iniciar while ocupado=1 SHALL be ignored; erro cleared only on INICIAL→ESPERA_FRAME.

Reset
REQ-035 reset low SHALL immediately force INICIAL, all counters/synchronisers 0, and we_byte, endereco, dado, pronto, ocupado, erro, db_estado = 0, including mid-frame.
REQ-036 After reset release no we_byte SHALL occur until a full new VSYNC falling edge is seen.

Verification (LARGURA=6, ALTURA=6, BYTES_PIXEL=2, QUAD 3x3, clock=8×PCLK)
REQ-037 Clean frame, descarta=0, continuo=0 → 18 we_byte, addresses 0..17 in order, bytes of pixels (1,1),(3,1),(5,1)…(5,5); one pronto; erro=0; return to INICIAL.
REQ-038 descarta=2 → no we_byte for 2 frames, pronto only after frame 3.
REQ-039 continuo=1, three frames → three pronto pulses, addresses 0..17 repeated; ocupado stays 1.
REQ-040 Line with 5 pixels → erro=1 at FIM_LINHA, frame still completes with pronto; erro holds until next iniciar.
REQ-041 reset low mid-line → all outputs 0 within same cycle; after release and iniciar, next full frame captures 18 bytes correctly.
REQ-042 iniciar pulsed during capture → no effect on state, counters or outputs.
